// File: rtl/param_seq_detector.sv
// param_seq_detector: parametrised serial sequence detector with valid qualifier and saturating match count (optional runtime pattern: SEQ_DET_RUNTIME_PATTERN_EN)
module param_seq_detector #(
   parameter int          PATTERN_W = 5,
   parameter logic [31:0] PATTERN   = 32'b10010,
   parameter bit          OVERLAP   = 1'b1,
   parameter int          COUNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in,
   input  logic                 in_valid,
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
   input  logic [PATTERN_W-1:0] pat_in,
   input  logic                 pat_load,
`endif
   output logic                 done,
   output logic [COUNT_W-1:0]   match_count
);
   localparam int             FW      = $clog2(PATTERN_W + 1);
   localparam logic [FW-1:0]  FULL    = FW'(PATTERN_W);
   localparam logic [FW-1:0]  FULL_M1 = FW'(PATTERN_W - 1);
   if (PATTERN_W < 2 || PATTERN_W > 32) begin : g_bad_width
      $error("param_seq_detector: PATTERN_W must be within 2..32");
   end
   logic [PATTERN_W-1:0] hist_q, hist_d, shifted, pat;
   logic [FW-1:0]        fill_q, fill_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic                 done_q, done_d, load, take, match;
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
   logic [PATTERN_W-1:0] pat_q;
   // runtime pattern register, reloaded on pat_load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pat_q <= PATTERN[PATTERN_W-1:0];
      else if (pat_load) pat_q <= pat_in;
   end
   assign pat  = pat_q;
   assign load = pat_load;
`else
   assign pat  = PATTERN[PATTERN_W-1:0];
   assign load = 1'b0;
`endif
   // next-state: shift accepted bits, track fill, detect match on the post-shift history
   always_comb begin
      shifted = {hist_q[PATTERN_W-2:0], in};
      take    = in_valid && !load;
      match   = take && shifted == pat && fill_q >= FULL_M1;
      hist_d  = take ? shifted : hist_q;
      fill_d  = (load || (match && !OVERLAP)) ? '0 : (take && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
      cnt_d   = (match && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      done_d  = match;
   end
   // state registers, cleared asynchronously so partial sequences are discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
   assign done        = done_q;
   assign match_count = cnt_q;
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: three detector configurations driven by one bit stream, checked against a bit-history model
module tb_param_seq_detector;
   logic        clk = 1'b0, rst = 1'b0, in_b = 1'b0, in_valid = 1'b0, pat_load = 1'b0;
   logic [31:0] pat_in = '0;
   logic        done0, done1, done2;
   logic [7:0]  cnt0, cnt1;
   logic [1:0]  cnt2;
   int n_cmp = 0, n_err = 0, tally = 0;
   int              pw[3]   = '{5, 5, 2};
   longint unsigned dpat[3] = '{64'b10010, 64'b10010, 64'b11};
   bit              ov[3]   = '{1'b1, 1'b0, 1'b1};
   int              cmax[3] = '{255, 255, 3};
   longint unsigned pat[3], hv[3];
   int              nb[3], cnt[3];
   bit              ed[3];

   always #5 clk = ~clk;

   param_seq_detector u0 (.clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid),
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
      .pat_in(pat_in[4:0]), .pat_load(pat_load),
`endif
      .done(done0), .match_count(cnt0));
   param_seq_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid),
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
      .pat_in(pat_in[4:0]), .pat_load(pat_load),
`endif
      .done(done1), .match_count(cnt1));
   param_seq_detector #(.PATTERN_W(2), .PATTERN(32'b11), .OVERLAP(1'b1), .COUNT_W(2)) u2 (.clk(clk), .rst(rst),
      .in(in_b), .in_valid(in_valid),
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
      .pat_in(pat_in[1:0]), .pat_load(pat_load),
`endif
      .done(done2), .match_count(cnt2));

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_cmp++;
      assert (obs === 32'(exp)) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".done0"}, 32'(done0), int'(ed[0]));
      check({tag, ".cnt0"},  32'(cnt0),  cnt[0]);
      check({tag, ".done1"}, 32'(done1), int'(ed[1]));
      check({tag, ".cnt1"},  32'(cnt1),  cnt[1]);
      check({tag, ".done2"}, 32'(done2), int'(ed[2]));
      check({tag, ".cnt2"},  32'(cnt2),  cnt[2]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         pat[k] = dpat[k];
         hv[k]  = 0;
         nb[k]  = 0;
         cnt[k] = 0;
         ed[k]  = 1'b0;
      end
   endtask

   // history of accepted bits as an integer plus the number of bits seen since the last restart
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         longint unsigned mask = (64'd1 << pw[k]) - 1;
         ed[k] = 1'b0;
         if (pat_load) begin
            pat[k] = 64'(pat_in) & mask;
            nb[k]  = 0;
         end else if (in_valid) begin
            hv[k] = ((hv[k] << 1) | 64'(in_b)) & mask;
            nb[k]++;
            if (nb[k] >= pw[k] && hv[k] == pat[k]) begin
               ed[k]  = 1'b1;
               cnt[k] = cnt[k] < cmax[k] ? cnt[k] + 1 : cmax[k];
               if (!ov[k]) nb[k] = 0;
            end
         end
      end
   endtask

   // called at a falling edge: drive, take the rising edge, check at the next falling edge
   task automatic cyc(input bit b, input bit v, input bit ld, input string tag);
      in_b = b;
      in_valid = v;
      pat_load = ld;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
      pat_load = 1'b0;
   endtask

   task automatic bits(input logic [31:0] seq, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) cyc(seq[i], 1'b1, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      @(negedge clk);
      check_all({tag, ".held"});
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset("rst0");
      bits(32'b10010, 5, "basic");
      check("basic.done_const", 32'(done0), 1);
      check("basic.cnt_const", 32'(cnt0), 1);
      cyc(1'b0, 1'b0, 1'b0, "basic.after");
      check("basic.pulse_one_cycle", 32'(done0), 0);
      do_reset("rst1");
      bits(32'b10010010, 8, "ovl");
      check("ovl.cnt_overlap", 32'(cnt0), 2);
      check("ovl.cnt_nonoverlap", 32'(cnt1), 1);
      do_reset("rst2");
      bits(32'b10, 2, "gap");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, "gap.idle");
      bits(32'b010, 3, "gap");
      check("gap.cnt_const", 32'(cnt0), 1);
      do_reset("rst3");
      bits(32'b100, 3, "mid");
      do_reset("midrst");
      bits(32'b10, 2, "mid.partial");
      check("mid.no_done", 32'(done0), 0);
      do_reset("rst4");
      bits(32'b10010, 5, "mid.full");
      check("mid.cnt_const", 32'(cnt0), 1);
      do_reset("rst5");
      tally = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1, 1'b0, "sat");
         tally += int'(done2);
      end
      check("sat.done_cycles", 32'(tally), 5);
      check("sat.cnt_const", 32'(cnt2), 3);
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
      do_reset("rst6");
      pat_in = 32'b11011;
      cyc(1'b1, 1'b1, 1'b1, "load");
      bits(32'b11011, 5, "load.hit");
      check("load.done_const", 32'(done0), 1);
      bits(32'b10010, 5, "load.old");
      check("load.cnt_const", 32'(cnt0), 1);
`endif
      do_reset("rst7");
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset("rnd.rst");
`ifdef SEQ_DET_RUNTIME_PATTERN_EN
         pat_in = $urandom_range(0, 3) == 0 ? 32'b10010 : 32'($urandom_range(0, 31));
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0, "rnd");
`else
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, "rnd");
`endif
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
